// File: rtl/seq_datapath.sv
// seq_datapath: register file, A/B operands, shifter, ALU, C register and
// Z/N/V flags, sequenced by an FSM. Define SEQ_DATAPATH_SAT_EN for saturating ADD/SUB.
module seq_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IMM_W = 5,
    localparam int RW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cmd,
    input  logic [RW-1:0]    rd,
    input  logic [RW-1:0]    rn,
    input  logic [RW-1:0]    rm,
    input  logic [1:0]       ALUop,
    input  logic [1:0]       shift,
    input  logic [WIDTH-1:0] datapath_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] datapath_out,
    output logic             Z_out,
    output logic             N_out,
    output logic             V_out
);

    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] CMD_REG = 2'b00;
    localparam logic [1:0] CMD_IMM = 2'b01;
    localparam logic [1:0] CMD_MOV = 2'b10;
    localparam logic [1:0] CMD_CMP = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

`ifdef SEQ_DATAPATH_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADA,
        S_LOADB,
        S_EXEC,
        S_WB
    } state_t;

    state_t state_q, state_d;

    // Latched command fields
    logic [1:0]       cmd_q;
    logic [RW-1:0]    rd_q, rn_q, rm_q;
    logic [1:0]       aluop_q, shift_q;
    logic [WIDTH-1:0] din_q;

    // Datapath state
    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             v_q, v_d;

    logic             capture;
    logic             rf_we;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] alu_res;
    logic             ovf;

    assign capture = (state_q == S_IDLE) && start;
    assign rf_we   = (state_q == S_WB) && (cmd_q != CMD_CMP);
    assign imm_ext = {{(WIDTH-IMM_W){din_q[IMM_W-1]}}, din_q[IMM_W-1:0]};

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_WB);
    assign datapath_out = c_q;
    assign Z_out        = z_q;
    assign N_out        = n_q;
    assign V_out        = v_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; IMM skips LOADB, MOV skips both loads
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (cmd == CMD_MOV) ? S_EXEC : S_LOADA;
                end
            end
            S_LOADA: state_d = (cmd_q == CMD_IMM) ? S_EXEC : S_LOADB;
            S_LOADB: state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command capture; fields are free to change once the command is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q   <= CMD_REG;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            aluop_q <= OP_ADD;
            shift_q <= SH_NONE;
            din_q   <= '0;
        end else if (capture) begin
            cmd_q   <= cmd;
            rd_q    <= rd;
            rn_q    <= rn;
            rm_q    <= rm;
            aluop_q <= ALUop;
            shift_q <= shift;
            din_q   <= datapath_in;
        end
    end

    // One-bit shifter on the B operand
    always_comb begin
        b_sh = b_q;
        unique case (shift_q)
            SH_NONE: b_sh = b_q;
            SH_LSL:  b_sh = {b_q[MSB-1:0], 1'b0};
            SH_LSR:  b_sh = {1'b0, b_q[MSB:1]};
            SH_ASR:  b_sh = {b_q[MSB], b_q[MSB:1]};
            default: b_sh = b_q;
        endcase
    end

    // ALU with signed-overflow detection (and optional saturation)
    always_comb begin
        bin     = (cmd_q == CMD_IMM) ? imm_ext : b_sh;
        sum     = a_q + bin;
        dif     = a_q - bin;
        alu_res = sum;
        ovf     = 1'b0;
        unique case (aluop_q)
            OP_ADD: begin
                alu_res = sum;
                ovf = (a_q[MSB] == bin[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = dif;
                ovf = (a_q[MSB] != bin[MSB]) && (dif[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res = a_q & bin;
            OP_NOT: alu_res = ~bin;
            default: alu_res = sum;
        endcase
`ifdef SEQ_DATAPATH_SAT_EN
        // On overflow the true sign is the sign of A
        if (ovf) begin
            alu_res = a_q[MSB] ? MIN_NEG : MAX_POS;
        end
`endif
    end

    // Operand loads, result and flag updates per state
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        z_d = z_q;
        n_d = n_q;
        v_d = v_q;
        unique case (state_q)
            S_LOADA: a_d = rf_q[rn_q];
            S_LOADB: b_d = rf_q[rm_q];
            S_EXEC: begin
                if (cmd_q == CMD_MOV) begin
                    c_d = din_q;
                end else begin
                    c_d = alu_res;
                    z_d = (alu_res == '0);
                    n_d = alu_res[MSB];
                    v_d = ovf;
                end
            end
            default: begin
                a_d = a_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            z_q <= z_d;
            n_q <= n_d;
            v_q <= v_d;
        end
    end

    // Register file; written from C in WB except for CMP
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rd_q] <= c_q;
        end
    end

endmodule

// File: tb/tb_seq_datapath.sv
// Testbench for seq_datapath: table of command vectors plus hand-written
// sequences for ignored start pulses and reset in the middle of an operation.
module tb_seq_datapath;

    localparam logic [1:0] REG = 2'b00;
    localparam logic [1:0] IMM = 2'b01;
    localparam logic [1:0] MOV = 2'b10;
    localparam logic [1:0] CMP = 2'b11;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] NOT = 2'b11;
    localparam logic [1:0] SN = 2'b00;
    localparam logic [1:0] LSL = 2'b01;
    localparam logic [1:0] LSR = 2'b10;
    localparam logic [1:0] ASR = 2'b11;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  cmd;
    logic [2:0]  rd, rn, rm;
    logic [1:0]  ALUop, shift;
    logic [15:0] datapath_in;
    logic        busy, done;
    logic [15:0] datapath_out;
    logic        Z_out, N_out, V_out;

    int checks = 0;
    int failures = 0;

    seq_datapath #(.WIDTH(16), .NREGS(8), .IMM_W(5)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cmd(cmd),
        .rd(rd),
        .rn(rn),
        .rm(rm),
        .ALUop(ALUop),
        .shift(shift),
        .datapath_in(datapath_in),
        .busy(busy),
        .done(done),
        .datapath_out(datapath_out),
        .Z_out(Z_out),
        .N_out(N_out),
        .V_out(V_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  c;
        logic [2:0]  d, n, m;
        logic [1:0]  o, s;
        logic [15:0] din;
        logic [15:0] exp;
        logic        ez, en, ev;
        int          lat;
    } vec_t;

    vec_t tv[$];

    function automatic void add(
        logic [1:0] c, logic [2:0] d, logic [2:0] n, logic [2:0] m,
        logic [1:0] o, logic [1:0] s, logic [15:0] din,
        logic [15:0] exp, logic ez, logic en, logic ev, int lat);
        vec_t v;
        v.c = c; v.d = d; v.n = n; v.m = m; v.o = o; v.s = s;
        v.din = din; v.exp = exp; v.ez = ez; v.en = en; v.ev = ev;
        v.lat = lat;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one command and wait (bounded) for done; inputs scrambled after capture
    task automatic do_op(
        input logic [1:0] c, input logic [2:0] d, input logic [2:0] n,
        input logic [2:0] m, input logic [1:0] o, input logic [1:0] s,
        input logic [15:0] din,
        output logic [15:0] res, output logic z, output logic ng,
        output logic v, output int lat);
        @(negedge clk);
        cmd = c; rd = d; rn = n; rm = m;
        ALUop = o; shift = s; datapath_in = din;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cmd = 2'($urandom); rd = 3'($urandom);
            rn = 3'($urandom); rm = 3'($urandom);
            ALUop = 2'($urandom); shift = 2'($urandom);
            datapath_in = 16'($urandom);
            lat++;
        end while (!done && lat < 20);
        res = datapath_out;
        z = Z_out; ng = N_out; v = V_out;
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [15:0] val);
        logic z, ng, v;
        int lat;
        do_op(CMP, 3'd0, r, r, AND, SN, 16'h0, val, z, ng, v, lat);
    endtask

    initial begin
        logic [15:0] res;
        logic z, ng, v;
        int lat;
        logic [15:0] e8, e16;
        logic n8, n9, n16;

`ifdef SEQ_DATAPATH_SAT_EN
        e8 = 16'h7FFF; n8 = 1'b0; n9 = 1'b0;
        e16 = 16'h8000; n16 = 1'b1;
`else
        e8 = 16'h8000; n8 = 1'b1; n9 = 1'b1;
        e16 = 16'h7FF9; n16 = 1'b0;
`endif

        // c    d  n  m  op   sh   din       exp       Z  N  V  lat
        add(MOV, 0, 0, 0, ADD, SN, 16'h0007, 16'h0007, 0, 0, 0, 2);
        add(MOV, 1, 0, 0, ADD, SN, 16'h0002, 16'h0002, 0, 0, 0, 2);
        add(REG, 2, 0, 1, ADD, LSL, 16'h0, 16'h000B, 0, 0, 0, 4);
        add(CMP, 5, 0, 0, SUB, SN, 16'h0, 16'h0000, 1, 0, 0, 4);
        add(MOV, 5, 0, 0, ADD, SN, 16'h1234, 16'h1234, 1, 0, 0, 2);
        add(CMP, 0, 0, 0, AND, SN, 16'h0, 16'h0007, 0, 0, 0, 4);
        add(CMP, 0, 2, 2, AND, SN, 16'h0, 16'h000B, 0, 0, 0, 4);
        add(MOV, 3, 0, 0, ADD, SN, 16'h7FFF, 16'h7FFF, 0, 0, 0, 2);
        add(IMM, 4, 3, 0, ADD, SN, 16'h0001, e8, 0, n8, 1, 3);
        add(CMP, 0, 4, 4, AND, SN, 16'h0, e8, 0, n9, 0, 4);
        add(MOV, 1, 0, 0, ADD, SN, 16'h8004, 16'h8004, 0, n9, 0, 2);
        add(MOV, 7, 0, 0, ADD, SN, 16'hFFFF, 16'hFFFF, 0, n9, 0, 2);
        add(REG, 2, 7, 1, AND, ASR, 16'h0, 16'hC002, 0, 1, 0, 4);
        add(REG, 2, 7, 1, AND, LSR, 16'h0, 16'h4002, 0, 0, 0, 4);
        add(REG, 2, 0, 0, NOT, SN, 16'h0, 16'hFFF8, 0, 1, 0, 4);
        add(MOV, 5, 0, 0, ADD, SN, 16'h8000, 16'h8000, 0, 1, 0, 2);
        add(REG, 6, 5, 0, SUB, SN, 16'h0, e16, 0, n16, 1, 4);
        add(REG, 6, 0, 1, ADD, LSL, 16'h0, 16'h000F, 0, 0, 0, 4);
        add(IMM, 6, 7, 0, ADD, SN, 16'hFFE1, 16'h0000, 1, 0, 0, 3);
        add(REG, 0, 0, 0, ADD, SN, 16'h0, 16'h000E, 0, 0, 0, 4);
        add(CMP, 0, 0, 0, AND, SN, 16'h0, 16'h000E, 0, 0, 0, 4);
        add(IMM, 6, 2, 0, SUB, SN, 16'h0010, 16'h0008, 0, 0, 0, 3);

        reset = 1'b1; start = 1'b0;
        cmd = '0; rd = '0; rn = '0; rm = '0;
        ALUop = '0; shift = '0; datapath_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out", datapath_out, 16'h0);
        chk("rst_flags", {Z_out, N_out, V_out}, 3'b000);
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            do_op(tv[i].c, tv[i].d, tv[i].n, tv[i].m, tv[i].o, tv[i].s,
                  tv[i].din, res, z, ng, v, lat);
            chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
            chk($sformatf("v%0d_out", i), res, tv[i].exp);
            chk($sformatf("v%0d_Z", i), z, tv[i].ez);
            chk($sformatf("v%0d_N", i), ng, tv[i].en);
            chk($sformatf("v%0d_V", i), v, tv[i].ev);
        end

        // start pulses during LOADA/EXEC must be ignored
        do_op(MOV, 0, 0, 0, ADD, SN, 16'h0007, res, z, ng, v, lat);
        chk("mov_r0", res, 16'h0007);
        @(negedge clk);
        cmd = IMM; rd = 3'd6; rn = 3'd0; rm = 3'd0;
        ALUop = SUB; shift = SN; datapath_in = 16'h001F;
        start = 1'b1;
        @(negedge clk);
        chk("ign_busy1", {busy, done}, 2'b10);
        cmd = MOV; rd = 3'd0; datapath_in = 16'hAAAA;
        @(negedge clk);
        chk("ign_busy2", {busy, done}, 2'b10);
        @(negedge clk);
        start = 1'b0;
        chk("ign_done3", {busy, done}, 2'b11);
        chk("ign_out", datapath_out, 16'h0008);
        chk("ign_flags", {Z_out, N_out, V_out}, 3'b000);
        @(negedge clk);
        chk("ign_idle", {busy, done}, 2'b00);
        chk("ign_hold", datapath_out, 16'h0008);
        read_reg(3'd0, res);
        chk("ign_r0", res, 16'h0007);
        read_reg(3'd6, res);
        chk("ign_r6", res, 16'h0008);

        // reset asserted during EXEC
        do_op(IMM, 3, 3, 0, ADD, SN, 16'h0001, res, z, ng, v, lat);
        chk("pre_V", v, 1'b1);
        @(negedge clk);
        cmd = REG; rd = 3'd0; rn = 3'd0; rm = 3'd0;
        ALUop = ADD; shift = SN; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("exec_busy", {busy, done}, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_out", datapath_out, 16'h0);
        chk("mid_flags", {Z_out, N_out, V_out}, 3'b000);
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), res);
            chk($sformatf("clr_r%0d", r), res, 16'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
